// File: rtl/muldiv_seq_if.sv
// Handshake and result bundle between the execute stage and the multiply/divide sequencer.
// The master side issues requests; the slave side (the sequencer) returns status and HI/LO.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, flush,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: radix-2 shift-add multiplier and restoring divider
// working on operand magnitudes, with sign fix-up applied when HI/LO are written.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic               is_div_reg;
    logic               neg_hi_reg, neg_lo_reg;
    logic [WIDTH-1:0]   opa_reg;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_reg;      // {partial product, multiplier} or {remainder, dividend/quotient}
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;

    logic               accept, signed_op, rs_neg, rt_neg, div_zero;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fixed;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign accept    = (state_reg == IDLE) && bus.start && !bus.flush;
    assign signed_op = !bus.op[0];
    assign rs_neg    = signed_op && bus.rs_val[WIDTH-1];
    assign rt_neg    = signed_op && bus.rt_val[WIDTH-1];
    assign rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
    assign rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;
    assign div_zero  = bus.op[1] && (bus.rt_val == '0);

    // Carry out of the add lands in the top bit before the right shift.
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opa_reg} : '0);
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opa_reg};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};

    assign prod_fixed = neg_lo_reg ? -acc_reg : acc_reg;
    assign res_hi = is_div_reg ? (neg_hi_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH])
                               : prod_fixed[2*WIDTH-1:WIDTH];
    assign res_lo = is_div_reg ? (neg_lo_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0])
                               : prod_fixed[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (!bus.op[1])    state_next = MUL_RUN;
                    else if (div_zero) state_next = DONE;
                    else               state_next = DIV_RUN;
                end
            end
            MUL_RUN, DIV_RUN: begin
                bus.busy = 1'b1;
                if (bus.flush)             state_next = IDLE;
                else if (cnt_reg == 'd1)   state_next = DONE;
            end
            DONE: begin
                bus.done   = !bus.flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.stall = bus.busy || (bus.start && (state_reg == IDLE));
    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
            neg_lo_reg <= 1'b0;
            opa_reg    <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        is_div_reg <= bus.op[1];
                        cnt_reg    <= CNT_W'(WIDTH);
                        if (div_zero) begin
                            // Raw dividend goes to HI, all ones to LO, no sign fix-up.
                            neg_hi_reg <= 1'b0;
                            neg_lo_reg <= 1'b0;
                            acc_reg    <= {bus.rs_val, {WIDTH{1'b1}}};
                        end else if (!bus.op[1]) begin
                            neg_hi_reg <= rs_neg ^ rt_neg;
                            neg_lo_reg <= rs_neg ^ rt_neg;
                            opa_reg    <= rs_mag;
                            acc_reg    <= {{WIDTH{1'b0}}, rt_mag};
                        end else begin
                            neg_hi_reg <= rs_neg;
                            neg_lo_reg <= rs_neg ^ rt_neg;
                            opa_reg    <= rt_mag;
                            acc_reg    <= {{WIDTH{1'b0}}, rs_mag};
                        end
                    end
                end
                MUL_RUN: begin
                    acc_reg <= mul_next;
                    cnt_reg <= cnt_reg - 1'b1;
                end
                DIV_RUN: begin
                    acc_reg <= div_next;
                    cnt_reg <= cnt_reg - 1'b1;
                end
                DONE: begin
                    if (!bus.flush) begin
                        hi_reg <= res_hi;
                        lo_reg <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: arithmetic results, latency, divide-by-zero,
// overflow, reset mid-operation, flush and ignored start requests.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, measure latency to done, then check HI/LO.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_lat);
        int k;
        int nbusy;
        @(negedge clk);
        bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
        #1 check({tag, "_stall"}, 64'(bus.stall), 64'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0; nbusy = 0;
        while (!bus.done && k < 200) begin
            if (bus.busy) nbusy++;
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        $display("op %-10s op=%0d rs=%h rt=%h -> hi=%h lo=%h latency=%0d",
                 tag, o, a, b, bus.hi, bus.lo, k);
    endtask

    initial begin
        int ndone;
        int nbusy;
        int k;
        bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0; bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        @(negedge clk) rst = 1'b0;

        run_op("mulu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.op = 2'b00; bus.rs_val = 32'd9; bus.rt_val = 32'd9; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_hi", 64'(bus.hi), 64'd0);
        check("midrst_lo", 64'(bus.lo), 64'd0);
        $display("op midrst     reset asserted during MUL_RUN busy=%0d hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        @(negedge clk) rst = 1'b0;

        run_op("mul_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 32);
        run_op("mul_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32);
        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32);

        // Flush during the fifth DIV_RUN cycle: no done, HI/LO untouched.
        @(negedge clk);
        bus.op = 2'b11; bus.rs_val = 32'd100; bus.rt_val = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) bus.flush = 1'b1;
        ndone = bus.done ? 1 : 0;
        @(posedge clk); #1 bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (bus.done) ndone++;
            @(posedge clk); #1;
        end
        check("flush_no_done", 64'(ndone), 64'd0);
        check("flush_hi", 64'(bus.hi), 64'hFFFFFFFF);
        check("flush_lo", 64'(bus.lo), 64'hFFFFFFFD);
        $display("op flush      DIVU flushed in DIV_RUN hi=%h lo=%h", bus.hi, bus.lo);

        run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 32);
        run_op("div_negrt", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 32);
        run_op("divu_zero", 2'b11, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 0);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32);
        run_op("div_zero", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);

        // A start pulse while busy must not launch a second operation.
        @(negedge clk);
        bus.op = 2'b01; bus.rs_val = 32'd5; bus.rt_val = 32'd6; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.op = 2'b11; bus.rs_val = 32'd100; bus.rt_val = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("ign_latency", 64'(k), 64'd28);
        @(posedge clk); #1;
        check("ign_hi", 64'(bus.hi), 64'd0);
        check("ign_lo", 64'(bus.lo), 64'd30);
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) nbusy++;
            @(posedge clk); #1;
        end
        check("ign_no_second", 64'(nbusy), 64'd0);
        $display("op ignstart   MULU 5*6 with stray start hi=%h lo=%h", bus.hi, bus.lo);

        // start together with flush in IDLE is refused.
        @(negedge clk);
        bus.op = 2'b01; bus.rs_val = 32'd3; bus.rt_val = 32'd3; bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
        check("flushstart_busy", 64'(bus.busy), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) ndone++;
            @(posedge clk); #1;
        end
        check("flushstart_no_done", 64'(ndone), 64'd0);
        check("flushstart_lo", 64'(bus.lo), 64'd30);
        $display("op flushstart start+flush in IDLE ignored lo=%h", bus.lo);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
